// File: rtl/decoder_pkg.sv
// Shared widths and decode helper for the 2-to-4 line decoder.
package decoder_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned OUT_N = 4;

    // One-hot decode of sel, gated by en; all zeros when disabled.
    function automatic logic [OUT_N-1:0] onehot_decode(input logic [SEL_W-1:0] sel,
                                                       input logic             en);
        logic [OUT_N-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < OUT_N; i++) begin
            d[i] = en & (sel == SEL_W'(i));
        end
        return d;
    endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Purely combinational dataflow decode: one line high per select value when enabled.
module decoder_2to4_core
    import decoder_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_N-1:0] d_raw
);

    assign d_raw = onehot_decode(sel, en);

endmodule

// File: rtl/decoder_df.sv
// 2-to-4 decoder top: dataflow core, optional polarity inversion, optional output register.
module decoder_df
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0,
    parameter bit REG_OUT        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic EN,
    input  logic A0,
    input  logic A1,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3
);

    localparam logic [OUT_N-1:0] IDLE_VAL = OUT_ACTIVE_LOW ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

    logic [OUT_N-1:0] d_raw;
    logic [OUT_N-1:0] d_core;
    logic [OUT_N-1:0] d_out;

    decoder_2to4_core u_core (
        .en    (EN),
        .sel   ({A1, A0}),
        .d_raw (d_raw)
    );

    // XOR with the idle pattern flips every line when outputs are one-cold.
    assign d_core = d_raw ^ IDLE_VAL;

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_out <= IDLE_VAL;
                end else begin
                    d_out <= d_core;
                end
            end
        end else begin : g_comb
            // clk and rst have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign d_out = d_core;
        end
    endgenerate

    assign {D3, D2, D1, D0} = d_out;

endmodule

// File: tb/tb_decoder_df.sv
// Directed bench for decoder_df: registered active-high, registered active-low and combinational builds.
module tb_decoder_df;

    logic clk;
    logic rst;
    logic en;
    logic a0;
    logic a1;

    logic h0, h1, h2, h3;
    logic l0, l1, l2, l3;
    logic c0, c1, c2, c3;

    int n_tests;
    int n_fail;

    decoder_df #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) u_hi (
        .clk(clk), .rst(rst), .EN(en), .A0(a0), .A1(a1),
        .D0(h0), .D1(h1), .D2(h2), .D3(h3)
    );

    decoder_df #(.OUT_ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) u_lo (
        .clk(clk), .rst(rst), .EN(en), .A0(a0), .A1(a1),
        .D0(l0), .D1(l1), .D2(l2), .D3(l3)
    );

    decoder_df #(.OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) u_cb (
        .clk(clk), .rst(rst), .EN(en), .A0(a0), .A1(a1),
        .D0(c0), .D1(c1), .D2(c2), .D3(c3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] hi_out();
        return {h3, h2, h1, h0};
    endfunction

    function automatic logic [3:0] lo_out();
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [3:0] cb_out();
        return {c3, c2, c1, c0};
    endfunction

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; a1 = 1'b1; a0 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_tests++;
            if (hi_out() !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hi cyc%0d: got %b want 0000", c, hi_out());
            end
            n_tests++;
            if (lo_out() !== 4'b1111) begin
                n_fail++;
                $display("FAIL reset_lo cyc%0d: got %b want 1111", c, lo_out());
            end
        end
        rst = 1'b0;
        #2;
        n_tests++;
        if (hi_out() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release_hold: got %b want 0000", hi_out());
        end
        step();
        n_tests++;
        if (hi_out() !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_first_load: got %b want 1000", hi_out());
        end
    endtask

    task automatic test_disabled();
        logic [1:0] s;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            {a1, a0} = s;
            step();
            n_tests++;
            if (hi_out() !== 4'b0000) begin
                n_fail++;
                $display("FAIL disabled_hi sel=%b: got %b want 0000", s, hi_out());
            end
            n_tests++;
            if (lo_out() !== 4'b1111) begin
                n_fail++;
                $display("FAIL disabled_lo sel=%b: got %b want 1111", s, lo_out());
            end
        end
    endtask

    task automatic test_sweep();
        logic [3:0] exp_hi [4];
        logic [3:0] prev;
        logic [1:0] s;
        exp_hi[0] = 4'b0001;
        exp_hi[1] = 4'b0010;
        exp_hi[2] = 4'b0100;
        exp_hi[3] = 4'b1000;
        en = 1'b1;
        prev = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            {a1, a0} = s;
            #2;
            n_tests++;
            if (hi_out() !== prev) begin
                n_fail++;
                $display("FAIL sweep_latency sel=%b: got %b want %b", s, hi_out(), prev);
            end
            step();
            n_tests++;
            if (hi_out() !== exp_hi[i]) begin
                n_fail++;
                $display("FAIL sweep_hi sel=%b: got %b want %b", s, hi_out(), exp_hi[i]);
            end
            n_tests++;
            if (lo_out() !== ~exp_hi[i]) begin
                n_fail++;
                $display("FAIL sweep_lo sel=%b: got %b want %b", s, lo_out(), ~exp_hi[i]);
            end
            prev = exp_hi[i];
        end
    endtask

    task automatic test_en_toggle();
        logic [3:0] exp_seq [3];
        logic       en_seq  [3];
        exp_seq[0] = 4'b0010; en_seq[0] = 1'b1;
        exp_seq[1] = 4'b0000; en_seq[1] = 1'b0;
        exp_seq[2] = 4'b0010; en_seq[2] = 1'b1;
        a1 = 1'b0; a0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en = en_seq[i];
            step();
            n_tests++;
            if (hi_out() !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL en_toggle step%0d: got %b want %b", i, hi_out(), exp_seq[i]);
            end
        end
    endtask

    task automatic test_mid_reset_polarity();
        en = 1'b1; a1 = 1'b1; a0 = 1'b0;
        step();
        n_tests++;
        if (hi_out() !== 4'b0100 || lo_out() !== 4'b1011) begin
            n_fail++;
            $display("FAIL midrst_pre: got hi=%b lo=%b want hi=0100 lo=1011", hi_out(), lo_out());
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (hi_out() !== 4'b0000 || lo_out() !== 4'b1111) begin
            n_fail++;
            $display("FAIL midrst_clear: got hi=%b lo=%b want hi=0000 lo=1111", hi_out(), lo_out());
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (hi_out() !== 4'b0100 || lo_out() !== 4'b1011) begin
            n_fail++;
            $display("FAIL midrst_resume: got hi=%b lo=%b want hi=0100 lo=1011", hi_out(), lo_out());
        end
    endtask

    task automatic test_back_to_back();
        // EN and select change together; output shows only the new combined value.
        en = 1'b0; a1 = 1'b0; a0 = 1'b0;
        step();
        en = 1'b1; a1 = 1'b1; a0 = 1'b1;
        step();
        n_tests++;
        if (hi_out() !== 4'b1000) begin
            n_fail++;
            $display("FAIL b2b_combined: got %b want 1000", hi_out());
        end
        en = 1'b0; a1 = 1'b0; a0 = 1'b1;
        step();
        n_tests++;
        if (hi_out() !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_disable: got %b want 0000", hi_out());
        end
    endtask

    task automatic test_comb();
        logic [3:0] exp_cb [4];
        logic [1:0] s;
        exp_cb[0] = 4'b0001;
        exp_cb[1] = 4'b0010;
        exp_cb[2] = 4'b0100;
        exp_cb[3] = 4'b1000;
        @(negedge clk);
        en = 1'b1; a1 = 1'b1; a0 = 1'b1;
        #1;
        n_tests++;
        if (cb_out() !== 4'b1000) begin
            n_fail++;
            $display("FAIL comb_immediate: got %b want 1000", cb_out());
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (cb_out() !== 4'b1000) begin
            n_fail++;
            $display("FAIL comb_rst_ignored: got %b want 1000", cb_out());
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            {a1, a0} = s;
            #1;
            n_tests++;
            if (cb_out() !== exp_cb[i]) begin
                n_fail++;
                $display("FAIL comb_sel sel=%b: got %b want %b", s, cb_out(), exp_cb[i]);
            end
        end
        en = 1'b0;
        #1;
        n_tests++;
        if (cb_out() !== 4'b0000) begin
            n_fail++;
            $display("FAIL comb_disabled: got %b want 0000", cb_out());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b0; a0 = 1'b0; a1 = 1'b0;
        test_reset();
        test_disabled();
        test_sweep();
        test_en_toggle();
        test_mid_reset_polarity();
        test_back_to_back();
        test_comb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
